// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Contents: arb_state_t, requester_t, size constants, bound-check helper.
package tinker_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      ERR
   } arb_state_t;

   typedef enum logic {
      REQ_FETCH,
      REQ_DATA
   } requester_t;

   localparam int unsigned MEM_BYTES_DEFAULT = 524288;
   localparam int unsigned FETCH_BYTES       = 4;
   localparam int unsigned DATA_BYTES        = 8;

   // Evaluated at 65 bits so an address near 2^64-1 cannot wrap into range.
   function automatic logic out_of_range(input logic [63:0] addr,
                                         input int unsigned nbytes,
                                         input int unsigned mem_bytes);
      logic [64:0] end_addr;
      end_addr = {1'b0, addr} + 65'(nbytes);
      return end_addr > 65'(mem_bytes);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM signal bundle for the memory port arbiter
// Fetch port: f_req/f_addr in, f_ack/f_rdata/f_err out.
// Data port:  d_req/d_we/d_addr/d_wdata in, d_ack/d_rdata/d_err out.
// RAM port:   m_en/m_we/m_addr/m_wdata out, m_rdata in.
// slave = arbiter view, master = cpu + RAM view.
interface mem_port_arbiter_if;

   logic        f_req;
   logic [63:0] f_addr;
   logic        f_ack;
   logic [31:0] f_rdata;
   logic        f_err;

   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_ack;
   logic [63:0] d_rdata;
   logic        d_err;

   logic        m_en;
   logic        m_we;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic [63:0] m_rdata;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
      output m_en, m_we, m_addr, m_wdata
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
      input  m_en, m_we, m_addr, m_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - combinational two-way round-robin choice
// Ports: req_f_i, req_d_i (requests), last_grant_i (previous winner),
//        grant_o (winner), grant_valid_o (any request present).
module rr_arb2
   import tinker_mem_pkg::*;
(
   input  logic       req_f_i,
   input  logic       req_d_i,
   input  requester_t last_grant_i,
   output requester_t grant_o,
   output logic       grant_valid_o
);

   always_comb begin
      grant_valid_o = req_f_i | req_d_i;
      grant_o       = REQ_FETCH;
      if (req_f_i && req_d_i) begin
         // On a tie the requester that did not win last time goes next.
         grant_o = (last_grant_i == REQ_DATA) ? REQ_FETCH : REQ_DATA;
      end else if (req_d_i) begin
         grant_o = REQ_DATA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported RAM between fetch and data requesters
// Ports: clk (rising edge), reset (async, active low),
//        bus (mem_port_arbiter_if.slave: fetch, data and RAM signals).
// Params: MEM_BYTES (RAM size in bytes), MEM_LAT (1..7 cycles m_en -> m_rdata).
module mem_port_arbiter
   import tinker_mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_port_arbiter_if.slave     bus
);

   arb_state_t  state_q, state_d;
   requester_t  gnt_q, gnt_d;
   requester_t  last_grant_q, last_grant_d;
   logic [63:2] addr_q, addr_d;
   logic        we_q, we_d;
   logic [63:0] wdata_q, wdata_d;
   logic [2:0]  cnt_q, cnt_d;

   requester_t  arb_grant;
   logic        arb_valid;

   rr_arb2 u_rr_arb2 (
      .req_f_i       (bus.f_req),
      .req_d_i       (bus.d_req),
      .last_grant_i  (last_grant_q),
      .grant_o       (arb_grant),
      .grant_valid_o (arb_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         gnt_q        <= REQ_FETCH;
         last_grant_q <= REQ_DATA;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
      end
   end

   // All outputs are decoded from the state, so reset (state IDLE) forces
   // them to zero immediately without waiting for a clock edge.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;

      bus.f_ack    = 1'b0;
      bus.f_rdata  = '0;
      bus.f_err    = 1'b0;
      bus.d_ack    = 1'b0;
      bus.d_rdata  = '0;
      bus.d_err    = 1'b0;
      bus.m_en     = 1'b0;
      bus.m_we     = 1'b0;
      bus.m_addr   = '0;
      bus.m_wdata  = '0;

      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d        = arb_grant;
               last_grant_d = arb_grant;
               if (arb_grant == REQ_DATA) begin
                  addr_d  = bus.d_addr[63:2];
                  we_d    = bus.d_we;
                  wdata_d = bus.d_wdata;
                  if ((bus.d_addr[2:0] != 3'd0) ||
                      out_of_range(bus.d_addr, DATA_BYTES, MEM_BYTES)) begin
                     state_d = ERR;
                  end else begin
                     state_d = ISSUE;
                  end
               end else begin
                  addr_d  = bus.f_addr[63:2];
                  we_d    = 1'b0;
                  wdata_d = '0;
                  if ((bus.f_addr[1:0] != 2'd0) ||
                      out_of_range(bus.f_addr, FETCH_BYTES, MEM_BYTES)) begin
                     state_d = ERR;
                  end else begin
                     state_d = ISSUE;
                  end
               end
            end
         end

         ISSUE: begin
            bus.m_en    = 1'b1;
            bus.m_we    = we_q;
            bus.m_addr  = {addr_q[63:3], 3'b000};
            bus.m_wdata = wdata_q;
            if (MEM_LAT > 1) begin
               // WAIT spends MEM_LAT-1 cycles; the count is consumed down to 1.
               cnt_d   = 3'(MEM_LAT - 1);
               state_d = WAIT;
            end else begin
               state_d = RESP;
            end
         end

         WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         RESP: begin
            if (gnt_q == REQ_DATA) begin
               bus.d_ack   = 1'b1;
               bus.d_rdata = we_q ? 64'd0 : bus.m_rdata;
            end else begin
               bus.f_ack   = 1'b1;
               // The RAM returns a whole dword; pick the word the address named.
               bus.f_rdata = addr_q[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
            end
            state_d = IDLE;
         end

         ERR: begin
            if (gnt_q == REQ_DATA) begin
               bus.d_ack = 1'b1;
               bus.d_err = 1'b1;
            end else begin
               bus.f_ack = 1'b1;
               bus.f_err = 1'b1;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at MEM_LAT 1 and 3
module tb_mem_port_arbiter;

   typedef struct {
      bit          is_d;
      logic [63:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int men1     = 0;
   int men3     = 0;
   logic [63:0] maddr1 = '0;

   logic clk    = 1'b0;
   logic reset1 = 1'b0;
   logic reset3 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if bus1 ();
   mem_port_arbiter_if bus3 ();

   mem_port_arbiter #(.MEM_BYTES(524288), .MEM_LAT(1)) u_dut1 (
      .clk   (clk),
      .reset (reset1),
      .bus   (bus1)
   );

   mem_port_arbiter #(.MEM_BYTES(524288), .MEM_LAT(3)) u_dut3 (
      .clk   (clk),
      .reset (reset3),
      .bus   (bus3)
   );

   logic [63:0] mem1 [0:511];
   logic [63:0] mem3 [0:511];

   always @(posedge clk) begin
      if (bus1.m_en) begin
         if (bus1.m_we) mem1[bus1.m_addr[11:3]] <= bus1.m_wdata;
         else           bus1.m_rdata <= mem1[bus1.m_addr[11:3]];
      end
   end

   always @(posedge clk) begin
      if (bus3.m_en) begin
         if (bus3.m_we) mem3[bus3.m_addr[11:3]] <= bus3.m_wdata;
         else           bus3.m_rdata <= mem3[bus3.m_addr[11:3]];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_ack(input int which, input logic fa, input logic da,
                            input logic [31:0] frd, input logic [63:0] drd,
                            input logic fe, input logic de);
      exp_t e;
      chk("dual_ack", {63'd0, fa & da}, 64'd0);
      if ((which == 1 && q1.size() == 0) || (which == 3 && q3.size() == 0)) begin
         checks++;
         failures++;
         $display("FAIL unexpected_ack: dut%0d acked at cycle %0d with nothing expected", which, cyc);
      end else begin
         e = (which == 1) ? q1.pop_front() : q3.pop_front();
         chk("ack_kind",  {63'd0, da}, {63'd0, e.is_d});
         chk("ack_rdata", da ? drd : {32'd0, frd}, e.rdata);
         chk("ack_err",   {63'd0, da ? de : fe}, {63'd0, e.err});
         chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
   endtask

   always @(negedge clk) begin
      if (bus1.f_ack || bus1.d_ack)
         check_ack(1, bus1.f_ack, bus1.d_ack, bus1.f_rdata, bus1.d_rdata, bus1.f_err, bus1.d_err);
      if (bus3.f_ack || bus3.d_ack)
         check_ack(3, bus3.f_ack, bus3.d_ack, bus3.f_rdata, bus3.d_rdata, bus3.f_err, bus3.d_err);
      if (bus1.m_en) begin
         men1++;
         maddr1 = bus1.m_addr;
      end
      if (bus3.m_en) men3++;
   end

   // One request: raise it, push the expectation, wait (bounded) for the ack, drop req.
   task automatic txn(input int which, input bit is_d, input bit we,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] exp_rd, input bit exp_err);
      exp_t e;
      int   lat;
      bit   got;
      lat = (which == 1) ? 1 : 3;
      @(posedge clk); #1;
      if (which == 1) begin
         if (is_d) begin
            bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
         end else begin
            bus1.f_req = 1'b1; bus1.f_addr = addr;
         end
      end else begin
         if (is_d) begin
            bus3.d_req = 1'b1; bus3.d_we = we; bus3.d_addr = addr; bus3.d_wdata = wdata;
         end else begin
            bus3.f_req = 1'b1; bus3.f_addr = addr;
         end
      end
      e.is_d  = is_d;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + (exp_err ? 1 : 1 + lat);
      if (which == 1) q1.push_back(e);
      else            q3.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (which == 1 && (is_d ? bus1.d_ack : bus1.f_ack)) begin got = 1'b1; break; end
         if (which == 3 && (is_d ? bus3.d_ack : bus3.f_ack)) begin got = 1'b1; break; end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout: dut%0d addr 0x%0h got no ack expected one", which, addr);
      end
      @(posedge clk); #1;
      if (which == 1) begin bus1.f_req = 1'b0; bus1.d_req = 1'b0; end
      else            begin bus3.f_req = 1'b0; bus3.d_req = 1'b0; end
   endtask

   initial begin
      int   n0;
      int   m0;
      int   acks;
      exp_t e;

      bus1.f_req = 1'b0; bus1.f_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = '0;  bus1.d_wdata = '0;
      bus3.f_req = 1'b0; bus3.f_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
      bus3.d_addr = '0;  bus3.d_wdata = '0;

      mem1[9'h020] = 64'h11223344_AABBCCDD;
      mem1[9'h1FF] = 64'h01020304_05060708;
      mem3[9'h008] = 64'h01234567_89ABCDEF;

      // Both requesters held high from reset: fetch wins the first tie, then strict alternation.
      bus1.f_req = 1'b1; bus1.f_addr = 64'h104;
      bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 64'h100;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl",   {58'd0, bus1.f_ack, bus1.d_ack, bus1.f_err, bus1.d_err, bus1.m_en, bus1.m_we}, 64'd0);
      chk("rst_m_addr", bus1.m_addr, 64'd0);
      chk("rst_wdata",  bus1.m_wdata, 64'd0);
      chk("rst_rdata",  bus1.d_rdata | {32'd0, bus1.f_rdata}, 64'd0);
      reset1 = 1'b1;
      reset3 = 1'b1;
      n0 = cyc;
      for (int k = 0; k < 6; k++) begin
         e.is_d  = (k % 2) == 1;
         e.rdata = e.is_d ? 64'h11223344_AABBCCDD : 64'h0000_0000_1122_3344;
         e.err   = 1'b0;
         e.cyc   = n0 + 2 + 3 * k;
         q1.push_back(e);
      end
      acks = 0;
      for (int i = 0; i < 40 && acks < 6; i++) begin
         @(negedge clk);
         if (bus1.f_ack || bus1.d_ack) acks++;
      end
      chk("contention_acks", 64'(acks), 64'd6);
      @(posedge clk); #1;
      bus1.f_req = 1'b0;
      bus1.d_req = 1'b0;

      // Single fetch of the upper word, exactly one RAM strobe at the aligned address.
      m0 = men1;
      txn(1, 1'b0, 1'b0, 64'h104, 64'd0, 64'h1122_3344, 1'b0);
      chk("fetch_men_count", 64'(men1 - m0), 64'd1);
      chk("fetch_m_addr", maddr1, 64'h100);

      // Store then load back.
      txn(1, 1'b1, 1'b1, 64'h200, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0);
      txn(1, 1'b1, 1'b0, 64'h200, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);

      // Last legal fetch word of the RAM.
      txn(1, 1'b0, 1'b0, 64'h7FFFC, 64'd0, 64'h0102_0304, 1'b0);

      // Errors: misaligned data, fetch past the end, data address that would wrap.
      m0 = men1;
      txn(1, 1'b1, 1'b0, 64'h7FFFC, 64'd0, 64'd0, 1'b1);
      txn(1, 1'b0, 1'b0, 64'h80000, 64'd0, 64'd0, 1'b1);
      txn(1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1);
      chk("err_no_men", 64'(men1 - m0), 64'd0);

      // MEM_LAT=3 load.
      txn(3, 1'b1, 1'b0, 64'h40, 64'd0, 64'h01234567_89ABCDEF, 1'b0);

      // Reset asserted while waiting on the RAM: no ack, outputs cleared at once.
      @(posedge clk); #1;
      bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 64'h40;
      @(posedge clk); #1;
      chk("lat3_issue_men", {63'd0, bus3.m_en}, 64'd1);
      @(posedge clk); #1;
      reset3 = 1'b0;
      #1;
      chk("rst_wait_ctrl", {58'd0, bus3.f_ack, bus3.d_ack, bus3.f_err, bus3.d_err, bus3.m_en, bus3.m_we}, 64'd0);
      chk("rst_wait_m_addr", bus3.m_addr, 64'd0);
      bus3.d_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset3 = 1'b1;

      // Fresh request after reset release completes normally.
      txn(3, 1'b1, 1'b0, 64'h40, 64'd0, 64'h01234567_89ABCDEF, 1'b0);

      repeat (6) @(posedge clk);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("q3_drained", 64'(q3.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported RAM between the CPU's instruction-fetch requester (read-only, 32-bit) and data requester (load/store, 64-bit).
- Round-robin arbitration, req/ack handshake, fixed memory latency.
- Bounds and alignment checked before any RAM access. Errors return an ack with err=1 and never touch memory.
- Sits between the cpu fetch/load-store logic and the ram instance.

Parameters:
- MEM_BYTES, 524288: RAM size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- MEM_LAT, 1: cycles from an m_en cycle to m_rdata valid; legal values 1..7.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  64  fetch byte address
- f_ack  out  1  one-cycle completion pulse
- f_rdata  out  32  instruction word, valid while f_ack=1
- f_err  out  1  valid while f_ack=1
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  64  data byte address
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  64  load data, valid while d_ack=1
- d_err  out  1  valid while d_ack=1
- m_en  out  1  RAM access strobe
- m_we  out  1  RAM write enable
- m_addr  out  64  RAM byte address, 8-aligned
- m_wdata  out  64  RAM write data
- m_rdata  in  64  RAM read data, little-endian

Behaviour:
- Reset (reset=0): asynchronous. State goes to IDLE, every output is 0, and last_grant=DATA, so fetch wins the first tie. A transaction in flight is dropped with no ack, and m_en falls immediately.
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - With one req high, that requester is granted.
  - With both high, the requester not equal to last_grant is granted.
  - The granted address, we and wdata are latched into internal registers, and last_grant is updated.
  - Checks on the latched request:
    - fetch: f_addr[1:0]!=0 or f_addr+4>MEM_BYTES is an error.
    - data: d_addr[2:0]!=0 or d_addr+8>MEM_BYTES is an error.
  - Next state is ERR on error, else ISSUE.
- ISSUE: one cycle.
  - m_en=1; m_addr = latched address with bits [2:0] cleared; m_we = d_we for data, 0 for fetch; m_wdata = d_wdata for data, 0 for fetch.
  - Next state is WAIT if MEM_LAT>1, else RESP.
  - m_en is high only in ISSUE.
- WAIT: a 3-bit counter runs MEM_LAT-1 cycles, then moves to RESP.
- RESP: one cycle. Pulses the granted ack with err=0, then returns to IDLE.
  - fetch: f_rdata = m_rdata[63:32] if addr[2]=1, else m_rdata[31:0].
  - load: d_rdata = m_rdata.
  - store: d_rdata = 0.
- ERR: one cycle. Pulses the granted ack with err=1 and rdata=0, then returns to IDLE.
- Latency, with the request sampled in IDLE during cycle N:
  - normal ack in cycle N+1+MEM_LAT;
  - error ack in cycle N+1.
- Handshake:
  - The requester holds req, addr and data stable until its ack and drops req in the cycle after the ack.
  - req still high in the IDLE cycle after an ack counts as a new request.
  - req is ignored outside IDLE.
  - Exactly one ack pulses per accepted request; f_ack and d_ack are never high together.
- Fairness: under continuous contention, grants strictly alternate, so each requester waits at most one transaction.
- Address arithmetic: bound checks are computed at 65 bits, so addr near 2^64-1 does not wrap and flags error.
- A request dropped before its ack is a protocol violation; the arbiter still completes the transaction.

Decomposition:
- Package tinker_mem_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP, ERR);
  - requester_t enum (REQ_FETCH, REQ_DATA);
  - MEM_BYTES_DEFAULT = 524288;
  - FETCH_BYTES = 4, DATA_BYTES = 8.
- One sub-module, rr_arb2: combinational two-way round-robin choice from the two reqs and last_grant, returning grant and a grant_valid bit.

Test Plan:
- Single fetch, f_addr=0x104, RAM dword 0x100 = 0x11223344_AABBCCDD, MEM_LAT=1 -> f_ack in cycle N+2 with f_rdata=0x11223344, f_err=0; m_en high exactly one cycle with m_addr=0x100.
- Store then load: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF_CAFEF00D, then load from 0x200 -> load d_rdata=0xDEADBEEF_CAFEF00D; store d_rdata=0, d_err=0 on both.
- Both req held high from reset for 6 transactions -> grant order F,D,F,D,F,D; never two acks in one cycle.
- Errors: d_addr=0x7FFFC (misaligned), then f_addr=0x80000 (out of range) -> each ack in cycle N+1 with err=1, m_en never asserted.
- MEM_LAT=3, load at 0x40 -> d_ack in cycle N+4; reset pulled low during WAIT -> outputs 0 immediately, no ack; a fresh request after reset release completes normally.
